// File: rtl/clk_div_pkg.sv
// Shared types and helpers for the programmable clock-divider bank.
// The helpers use 32-bit arithmetic so that (div+1) cannot overflow at any counter width.
package clk_div_pkg;
  localparam int CNT_W_DEF = 8;

  typedef logic [CNT_W_DEF-1:0] cnt_t;

  typedef struct packed {
    cnt_t div;
    cnt_t phase;
  } cfg_t;

  // Number of source ticks div_out stays high per period: ceil(div/2).
  function automatic logic [31:0] hi_len(input logic [31:0] div);
    return (div + 32'd1) >> 1;
  endfunction

  // Counter start value: phase limited to the last count of the period, 0 when halted.
  function automatic logic [31:0] clamp_phase(input logic [31:0] phase, input logic [31:0] div);
    if (div == 32'd0) return 32'd0;
    return (phase > div - 32'd1) ? div - 32'd1 : phase;
  endfunction
endpackage

// File: rtl/clk_div_bank_if.sv
// Configuration write port of the divider bank.
// Handshake: a write transfers on a clock edge where cfg_valid && cfg_ready; the master holds
// cfg_ch/cfg_div/cfg_phase stable while cfg_valid is high and cfg_ready is low.
interface clk_div_bank_if #(
  parameter int NUM_CH = 3,
  parameter int CNT_W  = 8
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_valid;
  logic             cfg_ready;
  logic [CH_W-1:0]  cfg_ch;
  logic [CNT_W-1:0] cfg_div;
  logic [CNT_W-1:0] cfg_phase;

  modport master (output cfg_valid, cfg_ch, cfg_div, cfg_phase, input cfg_ready);
  modport slave  (input cfg_valid, cfg_ch, cfg_div, cfg_phase, output cfg_ready);
endinterface

// File: rtl/clk_div_ch.sv
// One divider channel: period counter, shadow config with pending flag, registered outputs.
// Shadow config is applied only at terminal count (or immediately while inactive) to stay glitch-free.
module clk_div_ch
  import clk_div_pkg::*;
#(
  parameter int CNT_W   = CNT_W_DEF,
  parameter int DEF_DIV = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             src,
  input  logic             cfg_we,
  input  logic [CNT_W-1:0] cfg_div,
  input  logic [CNT_W-1:0] cfg_phase,
  output logic             pending,
  output logic             div_out,
  output logic             tick_out
);
  localparam logic [CNT_W-1:0] DEF = CNT_W'(DEF_DIV);
  localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt, div, phase, sh_div, sh_phase;
  logic [CNT_W-1:0] hi, restart, load;
  logic             active, term, apply;

  assign active  = en && (div != '0);
  assign term    = active && src && (cnt == div - ONE);
  assign apply   = pending && (term || !active);
  assign hi      = CNT_W'(hi_len(32'(div)));
  assign restart = CNT_W'(clamp_phase(32'(phase), 32'(div)));
  assign load    = CNT_W'(clamp_phase(32'(sh_phase), 32'(sh_div)));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      div      <= DEF;
      phase    <= '0;
      sh_div   <= DEF;
      sh_phase <= '0;
      pending  <= 1'b0;
      div_out  <= 1'b0;
      tick_out <= 1'b0;
    end else begin
      div_out  <= active && (cnt < hi);
      tick_out <= term;
      // cfg_we is gated by !pending upstream, so it never coincides with apply.
      if (apply) begin
        div     <= sh_div;
        phase   <= sh_phase;
        cnt     <= load;
        pending <= 1'b0;
      end else begin
        if (cfg_we) begin
          sh_div   <= cfg_div;
          sh_phase <= cfg_phase;
          pending  <= 1'b1;
        end
        if (!en)               cnt <= restart;
        else if (div == '0)    cnt <= '0;
        else if (src)          cnt <= term ? '0 : cnt + ONE;
      end
    end
  end
endmodule

// File: rtl/clk_div_bank.sv
// Multi-channel programmable clock-divider bank with optional cascading.
// Decodes config writes to channels and chains tick_out[i-1] into channel i when cascaded.
module clk_div_bank
  import clk_div_pkg::*;
#(
  parameter int NUM_CH  = 3,
  parameter int CNT_W   = CNT_W_DEF,
  parameter int CASCADE = 1,
  parameter int DEF_DIV = 2
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [NUM_CH-1:0] ch_en,
  clk_div_bank_if.slave     cfg,
  output logic [NUM_CH-1:0] pending,
  output logic [NUM_CH-1:0] div_out,
  output logic [NUM_CH-1:0] tick_out
);
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic [NUM_CH-1:0] src;
  logic [NUM_CH-1:0] cfg_we;

  // Out-of-range channel numbers leave cfg_ready high so the write drains and is dropped.
  always_comb begin
    cfg.cfg_ready = 1'b1;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cfg.cfg_ch == CH_W'(i)) cfg.cfg_ready = !pending[i];
    end
  end

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign cfg_we[i] = cfg.cfg_valid && !pending[i] && (cfg.cfg_ch == CH_W'(i));

    if (i == 0 || CASCADE == 0) begin : g_free
      assign src[i] = 1'b1;
    end else begin : g_casc
      assign src[i] = tick_out[i-1];
    end

    clk_div_ch #(
      .CNT_W   (CNT_W),
      .DEF_DIV (DEF_DIV)
    ) u_ch (
      .clk       (clk_in),
      .rst       (rst_in),
      .en        (ch_en[i]),
      .src       (src[i]),
      .cfg_we    (cfg_we[i]),
      .cfg_div   (cfg.cfg_div),
      .cfg_phase (cfg.cfg_phase),
      .pending   (pending[i]),
      .div_out   (div_out[i]),
      .tick_out  (tick_out[i])
    );
  end
endmodule

// File: tb/tb_clk_div_bank.sv
// Self-checking bench for clk_div_bank: vector table, directed corner sequences and a
// randomized run compared every cycle against a behavioural model of the divider rules.
module tb_clk_div_bank;
  localparam int NUM_CH  = 3;
  localparam int CNT_W   = 8;
  localparam int CASCADE = 1;
  localparam int DEF_DIV = 2;
  localparam int OW      = 3 * NUM_CH;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [NUM_CH-1:0] ch_en;
  logic [NUM_CH-1:0] pending, div_out, tick_out;

  clk_div_bank_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_if ();

  clk_div_bank #(
    .NUM_CH (NUM_CH), .CNT_W (CNT_W), .CASCADE (CASCADE), .DEF_DIV (DEF_DIV)
  ) dut (
    .clk_in (clk), .rst_in (rst), .ch_en (ch_en), .cfg (cfg_if),
    .pending (pending), .div_out (div_out), .tick_out (tick_out)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  bit armed = 1'b0;
  logic [OW-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int m_cnt[NUM_CH], m_div[NUM_CH], m_ph[NUM_CH], m_sdiv[NUM_CH], m_sph[NUM_CH];
  logic [NUM_CH-1:0] m_pend, m_dout, m_tick;

  function automatic int start_of(input int ph, input int n);
    if (n == 0) return 0;
    return (ph < n - 1) ? ph : n - 1;
  endfunction

  function automatic bit model_ready();
    if (int'(cfg_if.cfg_ch) >= NUM_CH) return 1'b1;
    return !m_pend[cfg_if.cfg_ch];
  endfunction

  task automatic model_step();
    int n_cnt[NUM_CH], n_div[NUM_CH], n_ph[NUM_CH], n_sdiv[NUM_CH], n_sph[NUM_CH];
    logic [NUM_CH-1:0] n_pend, n_dout, n_tick;
    bit src, act, term, wr;
    wr = cfg_if.cfg_valid && model_ready() && (int'(cfg_if.cfg_ch) < NUM_CH);
    n_cnt = m_cnt; n_div = m_div; n_ph = m_ph; n_sdiv = m_sdiv; n_sph = m_sph;
    n_pend = m_pend;
    for (int i = 0; i < NUM_CH; i++) begin
      src  = (i == 0 || CASCADE == 0) ? 1'b1 : m_tick[(i > 0) ? i - 1 : 0];
      act  = ch_en[i] && (m_div[i] != 0);
      term = act && src && (m_cnt[i] == m_div[i] - 1);
      n_dout[i] = act && (m_cnt[i] < (m_div[i] + 1) / 2);
      n_tick[i] = term;
      if (m_pend[i] && (term || !act)) begin
        n_div[i] = m_sdiv[i]; n_ph[i] = m_sph[i];
        n_cnt[i] = start_of(m_sph[i], m_sdiv[i]); n_pend[i] = 1'b0;
      end else if (!ch_en[i]) n_cnt[i] = start_of(m_ph[i], m_div[i]);
      else if (m_div[i] == 0) n_cnt[i] = 0;
      else if (src)           n_cnt[i] = (m_cnt[i] + 1) % m_div[i];
    end
    if (wr) begin
      n_sdiv[cfg_if.cfg_ch] = int'(cfg_if.cfg_div);
      n_sph[cfg_if.cfg_ch]  = int'(cfg_if.cfg_phase);
      n_pend[cfg_if.cfg_ch] = 1'b1;
    end
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        n_cnt[i] = 0; n_div[i] = DEF_DIV; n_ph[i] = 0; n_sdiv[i] = DEF_DIV; n_sph[i] = 0;
      end
      n_pend = '0; n_dout = '0; n_tick = '0;
    end
    m_cnt = n_cnt; m_div = n_div; m_ph = n_ph; m_sdiv = n_sdiv; m_sph = n_sph;
    m_pend = n_pend; m_dout = n_dout; m_tick = n_tick;
    exp_q.push_back({m_pend, m_tick, m_dout});
  endtask

  // ---------------- driver ----------------
  // One clock: check cfg_ready against the model, advance model, then compare outputs after the edge.
  task automatic step();
    logic [OW-1:0] e;
    #1;
    if (armed) check("cfg_ready", cfg_if.cfg_ready, model_ready());
    model_step();
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check("pending",  pending,  e[3*NUM_CH-1:2*NUM_CH]);
    check("tick_out", tick_out, e[2*NUM_CH-1:NUM_CH]);
    check("div_out",  div_out,  e[NUM_CH-1:0]);
    armed = 1'b1;
  endtask

  task automatic cfg_write(input int ch, input int n, input int ph);
    cfg_if.cfg_valid = 1'b1;
    cfg_if.cfg_ch    = 2'(ch);
    cfg_if.cfg_div   = 8'(n);
    cfg_if.cfg_phase = 8'(ph);
  endtask

  task automatic cfg_idle();
    cfg_if.cfg_valid = 1'b0;
  endtask

  task automatic wait_clear(input int ch, input string name);
    int n = 0;
    while (pending[ch] && n < 16) begin step(); n++; end
    check(name, pending[ch], 1'b0);
  endtask

  typedef struct {
    logic [NUM_CH-1:0] en;
    logic              dout0;
    logic              tick0;
  } vec_t;

  vec_t vecs[9];
  int   t_q[$];
  int   t1_q[$];
  bit   h0[64];

  initial begin
    vecs[0] = '{3'b001, 1'b1, 1'b0};
    vecs[1] = '{3'b001, 1'b0, 1'b1};
    vecs[2] = '{3'b001, 1'b1, 1'b0};
    vecs[3] = '{3'b001, 1'b0, 1'b1};
    vecs[4] = '{3'b001, 1'b1, 1'b0};
    vecs[5] = '{3'b001, 1'b0, 1'b1};
    vecs[6] = '{3'b000, 1'b0, 1'b0};
    vecs[7] = '{3'b001, 1'b1, 1'b0};
    vecs[8] = '{3'b001, 1'b0, 1'b1};

    rst = 1'b1; ch_en = '0;
    cfg_if.cfg_valid = 1'b0; cfg_if.cfg_ch = '0; cfg_if.cfg_div = '0; cfg_if.cfg_phase = '0;
    step(); step();
    check("reset_div_out", div_out, 3'b000);
    check("reset_tick_out", tick_out, 3'b000);
    check("reset_pending", pending, 3'b000);

    // Default divide-by-2 on channel 0 straight out of reset.
    rst = 1'b0;
    for (int k = 0; k < 9; k++) begin
      ch_en = vecs[k].en;
      step();
      check($sformatf("vec%0d_dout0", k), div_out[0], vecs[k].dout0);
      check($sformatf("vec%0d_tick0", k), tick_out[0], vecs[k].tick0);
    end

    // Out-of-range channel: accepted and discarded.
    cfg_write(3, 5, 0);
    #1 check("oor_ready", cfg_if.cfg_ready, 1'b1);
    step(); cfg_idle();
    check("oor_no_pending", pending, 3'b000);

    // Ratio change mid-period: old period completes, then period 4.
    t_q.delete();
    cfg_write(0, 4, 0);
    step(); cfg_idle();
    if (tick_out[0]) t_q.push_back(0);
    check("switch_pending", pending[0], 1'b1);
    #1 check("switch_ready_low", cfg_if.cfg_ready, 1'b0);
    for (int k = 1; k < 20; k++) begin
      step();
      if (tick_out[0]) t_q.push_back(k);
    end
    check("switch_cleared", pending[0], 1'b0);
    for (int j = 1; j < t_q.size(); j++)
      check("switch_min_gap", (t_q[j] - t_q[j-1] >= 2), 1'b1);
    check("switch_last_gap", t_q[t_q.size()-1] - t_q[t_q.size()-2], 4);

    // Cascade: ch0 N=3, ch1 N=2 -> tick1 every 6, one cycle after tick0.
    cfg_write(0, 3, 0); step(); cfg_idle();
    wait_clear(0, "n3_applied");
    cfg_write(1, 2, 0); step(); cfg_idle();
    wait_clear(1, "ch1_applied");
    ch_en = 3'b011;
    t1_q.delete();
    for (int k = 0; k < 40; k++) begin
      step();
      h0[k] = tick_out[0];
      if (tick_out[1]) t1_q.push_back(k);
    end
    check("casc_tick1_count", (t1_q.size() >= 5), 1'b1);
    foreach (t1_q[j]) begin
      if (t1_q[j] > 0) check("casc_after_tick0", h0[t1_q[j]-1], 1'b1);
      if (j > 0) check("casc_tick1_gap", t1_q[j] - t1_q[j-1], 6);
    end

    // Stall: second write to ch0 while pending; ch1 write proceeds.
    cfg_write(0, 5, 0); step();
    check("stall_pending0", pending[0], 1'b1);
    cfg_write(0, 6, 1);
    #1 check("stall_ready0", cfg_if.cfg_ready, 1'b0);
    step();
    cfg_write(1, 2, 1);
    #1 check("stall_ready1", cfg_if.cfg_ready, 1'b1);
    step(); cfg_idle();
    check("stall_pending1", pending[1], 1'b1);
    wait_clear(0, "stall_clear0");
    wait_clear(1, "stall_clear1");

    // Disable mid-count with phase 2, N=4; restart from phase.
    cfg_write(0, 4, 2); step(); cfg_idle();
    wait_clear(0, "ph_applied");
    step(); step(); step();
    ch_en[0] = 1'b0;
    step();
    check("dis_dout0", div_out[0], 1'b0);
    check("dis_tick0", tick_out[0], 1'b0);
    step(); step();
    ch_en[0] = 1'b1;
    step();
    check("reen_tick_1st", tick_out[0], 1'b0);
    step();
    check("reen_tick_2nd", tick_out[0], 1'b1);

    // Reset during a write and while pending.
    cfg_write(2, 7, 0); rst = 1'b1;
    step(); cfg_idle(); rst = 1'b0;
    check("rst_wr_pending", pending, 3'b000);
    check("rst_wr_dout", div_out, 3'b000);
    check("rst_wr_tick", tick_out, 3'b000);
    ch_en = 3'b001;
    cfg_write(0, 7, 0); step(); cfg_idle();
    check("rst_pre_pending", pending[0], 1'b1);
    rst = 1'b1; step(); rst = 1'b0;
    check("rst_pend_cleared", pending, 3'b000);
    check("rst_outs_zero", {div_out, tick_out}, 6'b0);
    step();
    check("rst_def_dout_a", div_out[0], 1'b1);
    step();
    check("rst_def_dout_b", div_out[0], 1'b0);
    check("rst_def_tick_b", tick_out[0], 1'b1);

    // Randomized traffic against the model.
    for (int k = 0; k < 3000; k++) begin
      rst = ($urandom_range(0, 399) == 0);
      if ($urandom_range(0, 24) == 0) ch_en = 3'($urandom);
      if ($urandom_range(0, 2) == 0) begin
        cfg_write($urandom_range(0, 3),
                  ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 7),
                  $urandom_range(0, 9));
      end else cfg_idle();
      step();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
